// File: rtl/imem_boot_loader_pkg.sv
// Shared FSM state type and stream-format constants for the boot loader.
// BOOT_LOADER_CHECKSUM_EN adds the CSUM state and the trailing checksum byte.
package imem_boot_loader_pkg;

  localparam int unsigned LEN_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CSUM_W     = 8;

  typedef enum logic [2:0] {
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
`ifdef BOOT_LOADER_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE,
    ST_ERR
  } boot_state_e;

endpackage

// File: rtl/imem_boot_loader_boot_word_assembler.sv
// Packs accepted payload bytes little-endian into 32-bit words and flags
// the byte that completes each word.
module boot_word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic        word_done_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;

  // Earlier bytes shift down so the first byte lands in bits 7:0.
  assign word_done_o = accept_i && (cnt_q == 2'(WORD_BYTES - 1));
  assign word_o      = {byte_i, shift_q};

  assign cnt_d   = accept_i ? cnt_q + 2'd1 : cnt_q;
  assign shift_d = accept_i ? {byte_i, shift_q[23:8]} : shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed byte image into instruction memory, then releases
// the core from reset. BOOT_LOADER_CHECKSUM_EN enables a trailing XOR check.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        core_rst_n,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] DEPTH32 = 32'(IMEM_DEPTH);
  localparam int unsigned LEN_W   = 8 * LEN_BYTES;

`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam boot_state_e ST_TAIL = ST_CSUM;
`else
  localparam boot_state_e ST_TAIL = ST_DONE;
`endif

  boot_state_e        state_q, state_d;
  logic [7:0]         len_lo_q, len_lo_d;
  logic [LEN_W-1:0]   n_q, n_d;
  logic [15:0]        idx_q, idx_d;
  logic               we_q, we_d;
  logic [31:0]        waddr_q, waddr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               core_rst_n_q, core_rst_n_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0]  csum_q, csum_d;
`endif

  logic               xfer;
  logic               word_done;
  logic [31:0]        word;
  logic [LEN_W-1:0]   len_full;

  assign byte_ready = (state_q != ST_DONE) && (state_q != ST_ERR);
  assign xfer       = byte_valid && byte_ready;
  assign len_full   = {byte_data, len_lo_q};

  boot_word_assembler u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .accept_i    (xfer && (state_q == ST_DATA)),
    .byte_i      (byte_data),
    .word_done_o (word_done),
    .word_o      (word)
  );

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    n_d      = n_q;
    idx_d    = idx_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      ST_LEN0: begin
        if (xfer) begin
          len_lo_d = byte_data;
          state_d  = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (xfer) begin
          n_d = len_full;
          if ({16'h0, len_full} > DEPTH32) begin
            state_d = ST_ERR;
          end else if (len_full == '0) begin
            state_d = ST_TAIL;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ byte_data;
`endif
          if (word_done) begin
            // Write strobe and address are registered, landing one cycle after the 4th byte.
            we_d    = 1'b1;
            waddr_d = BASE_ADDR + {14'h0, idx_q, 2'b00};
            wdata_d = word;
            idx_d   = idx_q + 16'd1;
            if (idx_q == n_q - 16'd1) begin
              state_d = ST_TAIL;
            end
          end
        end
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (xfer) begin
          state_d = (byte_data == csum_q) ? ST_DONE : ST_ERR;
        end
      end
`endif
      default: ;
    endcase
  end

  // Status outputs decode the next state so they change together with it.
  assign core_rst_n_d = (state_d == ST_DONE);
  assign done_d       = (state_d == ST_DONE);
  assign error_d      = (state_d == ST_ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LEN0;
      len_lo_q     <= '0;
      n_q          <= '0;
      idx_q        <= '0;
      we_q         <= 1'b0;
      waddr_q      <= BASE_ADDR;
      wdata_q      <= '0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      core_rst_n_q <= core_rst_n_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader against a stream-level reference model;
// exercises the BOOT_LOADER_CHECKSUM_EN scenarios when that macro is defined.
`timescale 1ns/1ps
module tb_imem_boot_loader;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, imem_we, core_rst_n, done, error;
  logic [31:0] imem_waddr, imem_wdata;

  imem_boot_loader #(.IMEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  stream[$];
  logic [63:0] exp_wr[$];
  logic [63:0] act_wr[$];
  logic [63:0] ref_wr[$];
  int          exp_total = 0;
  int          end_cnt = 0;
  int          xfer_cnt = 0;
  bit          exp_ok = 1'b0;
  bit          chk_en = 1'b0;
  bit          term;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: derive every write and the final outcome from the whole stream.
  task automatic build_model();
    int unsigned n;
    logic [31:0] w;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]  x;
    x = 8'h00;
`endif
    exp_wr.delete();
    act_wr.delete();
    n = {16'h0, stream[1], stream[0]};
    if (n > DEPTH) begin
      end_cnt   = 2;
      exp_ok    = 1'b0;
      exp_total = 0;
      return;
    end
    for (int k = 0; k < int'(n); k++) begin
      w = {stream[5+4*k], stream[4+4*k], stream[3+4*k], stream[2+4*k]};
`ifdef BOOT_LOADER_CHECKSUM_EN
      x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
`endif
      exp_wr.push_back({BASE + 32'(4 * k), w});
    end
    exp_total = int'(n);
`ifdef BOOT_LOADER_CHECKSUM_EN
    end_cnt = 2 + 4 * int'(n) + 1;
    exp_ok  = (stream[2 + 4 * int'(n)] == x);
`else
    end_cnt = 2 + 4 * int'(n);
    exp_ok  = 1'b1;
`endif
  endtask

  task automatic make_stream(input int n);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    stream.delete();
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      x = x ^ b;
      stream.push_back(b);
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    stream.push_back(x);
`endif
  endtask

  task automatic drive(input int nbytes, input int gap_pct);
    int i = 0;
    int cyc = 0;
    bit take;
    while (i < nbytes && cyc < 8 * nbytes + 64) begin
      if ($urandom_range(99) < gap_pct) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
      end else begin
        byte_valid = 1'b1;
        byte_data  = stream[i];
      end
      @(negedge clk);
      take = byte_valid && byte_ready;
      @(posedge clk);
      #1;
      if (take) i++;
      cyc++;
    end
    byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    chk_en     = 1'b0;
    byte_valid = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_imem_we", 64'(imem_we), 64'd0);
    chk("rst_imem_waddr", 64'(imem_waddr), 64'(BASE));
    chk("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_core_rst_n", 64'(core_rst_n), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_byte_ready", 64'(byte_ready), 64'd1);
    xfer_cnt = 0;
  endtask

  task automatic run_load(input int gap_pct);
    build_model();
    do_reset();
    chk_en = 1'b1;
    drive(stream.size(), gap_pct);
    repeat (4) @(posedge clk);
    #1;
    chk("writes_missing", 64'(exp_wr.size()), 64'd0);
    chk("final_done", 64'(done), 64'(exp_ok));
    chk("final_error", 64'(error), 64'(!exp_ok));
    chk("final_core_rst_n", 64'(core_rst_n), 64'(exp_ok));
    chk_en = 1'b0;
  endtask

  // Per-cycle comparison against the model; transfers counted after the checks.
  always @(negedge clk) begin
    if (chk_en) begin
      term = (xfer_cnt >= end_cnt);
      chk("byte_ready", 64'(byte_ready), 64'(!term));
      chk("done", 64'(done), 64'(term && exp_ok));
      chk("error", 64'(error), 64'(term && !exp_ok));
      chk("core_rst_n", 64'(core_rst_n), 64'(term && exp_ok));
      if (imem_we) begin
        act_wr.push_back({imem_waddr, imem_wdata});
        if (act_wr.size() > exp_total) chk("extra_write", 64'(act_wr.size()), 64'(exp_total));
        else chk("write", {imem_waddr, imem_wdata}, exp_wr.pop_front());
      end
      if (core_rst_n) chk("core_rst_n_before_last_write", 64'(exp_wr.size()), 64'd0);
      if (byte_valid && byte_ready) xfer_cnt++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Two-word image from a known program.
    stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
`ifdef BOOT_LOADER_CHECKSUM_EN
    stream.push_back(8'h69);
`endif
    build_model();
    chk("model_w0", exp_wr[0], {32'h0000_0000, 32'h0010_0513});
    chk("model_w1", exp_wr[1], {32'h0000_0004, 32'h0000_006F});
    run_load(0);
    chk("prog_act_w0", act_wr[0], {32'h0000_0000, 32'h0010_0513});
    chk("prog_act_w1", act_wr[1], {32'h0000_0004, 32'h0000_006F});
    chk("prog_done", 64'(done), 64'd1);

    // Empty image.
    stream = '{8'h00, 8'h00};
`ifdef BOOT_LOADER_CHECKSUM_EN
    stream.push_back(8'h00);
`endif
    build_model();
    chk("n0_model_writes", 64'(exp_wr.size()), 64'd0);
    build_model();
    do_reset();
    chk_en = 1'b1;
    drive(stream.size(), 0);
    for (int c = 0; c < 2 && !core_rst_n; c++) begin
      @(posedge clk);
      #1;
    end
    chk("n0_core_rst_n", 64'(core_rst_n), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    chk("n0_act_writes", 64'(act_wr.size()), 64'd0);
    chk("n0_done", 64'(done), 64'd1);

    // Oversized image followed by junk that must be ignored.
    stream.delete();
    stream.push_back(8'(DEPTH + 1));
    stream.push_back(8'((DEPTH + 1) >> 8));
    repeat (10) stream.push_back(8'($urandom));
    run_load(0);
    chk("big_error", 64'(error), 64'd1);
    chk("big_byte_ready", 64'(byte_ready), 64'd0);
    chk("big_core_rst_n", 64'(core_rst_n), 64'd0);
    chk("big_act_writes", 64'(act_wr.size()), 64'd0);

    // Largest allowed image.
    make_stream(DEPTH);
    run_load(0);
    chk("full_depth_done", 64'(done), 64'd1);
    chk("full_depth_writes", 64'(act_wr.size()), 64'(DEPTH));

    // Same 16-word image with and without source gaps.
    make_stream(16);
    run_load(0);
    ref_wr = act_wr;
    run_load(50);
    chk("gap_seq_len", 64'(act_wr.size()), 64'(ref_wr.size()));
    for (int i = 0; i < ref_wr.size() && i < act_wr.size(); i++)
      chk("gap_seq_word", act_wr[i], ref_wr[i]);

    // Abort after the third payload byte, then reload.
    make_stream(4);
    build_model();
    do_reset();
    chk_en = 1'b1;
    drive(5, 0);
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_no_we", 64'(imem_we), 64'd0);
    end
    make_stream(4);
    run_load(30);
    chk("reload_first_addr", act_wr[0] >> 32, 64'(BASE));
    chk("reload_done", 64'(done), 64'd1);

`ifdef BOOT_LOADER_CHECKSUM_EN
    stream = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    build_model();
    chk("csum_good_model", 64'(exp_ok), 64'd1);
    run_load(0);
    chk("csum_good_done", 64'(done), 64'd1);
    stream = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    build_model();
    chk("csum_bad_model", 64'(exp_ok), 64'd0);
    run_load(0);
    chk("csum_bad_error", 64'(error), 64'd1);
    chk("csum_bad_core_rst_n", 64'(core_rst_n), 64'd0);
`endif

    // Random images with random gaps.
    for (int r = 0; r < 3; r++) begin
      make_stream(int'($urandom_range(1, 12)));
      run_load(int'($urandom_range(0, 60)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
